// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - operand FIFO and sequencer feeding one MAC lane for a VEC_LEN-term dot product
//
// Purpose: buffers (A,B) operand pairs and, for each start pulse taken in IDLE,
// clears the MAC, streams exactly VEC_LEN pairs into it, and captures Cout as
// the result. The result is held on a valid/ready output until it is accepted.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start                            begin one dot product (honoured in IDLE only)
//   in_valid, in_ready, in_a, in_b   operand pair input (in_ready = !full)
//   mac_en, mac_clr, mac_a, mac_b    MAC controls; operands are the FIFO head
//   mac_cout                         MAC accumulator output
//   res_valid, res_ready, res_data   dot product result
//   busy                             sequencer is not in IDLE
module mac_dot_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_a,
    input  logic [DATA_WIDTH-1:0]     in_b,
    output logic                      mac_en,
    output logic                      mac_clr,
    output logic [DATA_WIDTH-1:0]     mac_a,
    output logic [DATA_WIDTH-1:0]     mac_b,
    input  logic [3*DATA_WIDTH-1:0]   mac_cout,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [3*DATA_WIDTH-1:0]   res_data,
    output logic                      busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(VEC_LEN + 1);
    localparam int RW = 3 * DATA_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    logic [2:0]            r_state;
    logic [TW-1:0]         r_term;
    logic [RW-1:0]         r_res_data;

    logic [DATA_WIDTH-1:0] r_mem_a [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_b [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // in_ready depends on the registered count only, so a pop in the same
    // cycle does not open a slot while full.
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = (r_state == S_RUN) && !w_empty;

    assign in_ready  = !w_full;
    assign mac_en    = w_pop;
    assign mac_clr   = (r_state == S_CLEAR);
    assign mac_a     = r_mem_a[r_rd_ptr];
    assign mac_b     = r_mem_b[r_rd_ptr];
    assign res_valid = (r_state == S_RESULT);
    assign res_data  = r_res_data;
    assign busy      = (r_state != S_IDLE);

    // Storage array carries no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_term     <= '0;
            r_res_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_term  <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_pop) begin
                        r_term <= r_term + TW'(1);
                        if (r_term == TW'(VEC_LEN - 1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // The last term was registered into the MAC on the
                    // previous edge, so Cout now holds the full sum.
                    r_res_data <= mac_cout;
                    r_state    <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
